// File: rtl/sha2_sched_pkg.sv
// Shared types, constants and sigma helpers for the SHA-2 message scheduler.
// Helpers take a 64-bit container plus the active word width (32 or 64).
package sha2_sched_pkg;

  localparam int BLK_WORDS = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    GEN
  } sched_state_e;

  localparam int S0_256_A = 7;
  localparam int S0_256_B = 18;
  localparam int S0_256_C = 3;
  localparam int S1_256_A = 17;
  localparam int S1_256_B = 19;
  localparam int S1_256_C = 10;

  localparam int S0_512_A = 1;
  localparam int S0_512_B = 8;
  localparam int S0_512_C = 7;
  localparam int S1_512_A = 19;
  localparam int S1_512_B = 61;
  localparam int S1_512_C = 6;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] r;
    if (w == 32) r = {32'd0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
    else         r = (x >> n) | (x << (64 - n));
    return r;
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    logic [63:0] r;
    if (w == 32)
      r = rotr(x, S0_256_A, 32) ^ rotr(x, S0_256_B, 32) ^ {32'd0, x[31:0] >> S0_256_C};
    else
      r = rotr(x, S0_512_A, 64) ^ rotr(x, S0_512_B, 64) ^ (x >> S0_512_C);
    return r;
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    logic [63:0] r;
    if (w == 32)
      r = rotr(x, S1_256_A, 32) ^ rotr(x, S1_256_B, 32) ^ {32'd0, x[31:0] >> S1_256_C};
    else
      r = rotr(x, S1_512_A, 64) ^ rotr(x, S1_512_B, 64) ^ (x >> S1_512_C);
    return r;
  endfunction

endpackage

// File: rtl/msg_sched_sigma.sv
// Combinational small-sigma pair: s0 of x0 (W[t-15]) and s1 of x1 (W[t-2]).
module msg_sched_sigma
  import sha2_sched_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x0,
  input  logic [WORD_W-1:0] x1,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  assign s0 = WORD_W'(sig0(64'(x0), WORD_W));
  assign s1 = WORD_W'(sig1(64'(x1), WORD_W));

endmodule

// File: rtl/msg_sched_stream.sv
// Streaming SHA-256/SHA-512 message scheduler: 16 loaded words, then generated W[t].
// Optional MSG_SCHED_STALL_CNT_EN adds saturating stall/starve counters.
module msg_sched_stream
  import sha2_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int RND_W  = $clog2(ROUNDS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              blk_start,
  input  logic              abort,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [WORD_W-1:0] m_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_data,
  output logic [RND_W-1:0]  w_round,
  output logic              w_last,
  output logic              busy
`ifdef MSG_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       starve_cnt
`endif
);

  generate
    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
      $error("msg_sched_stream: WORD_W/ROUNDS must be 32/64 or 64/80");
    end
  endgenerate

  localparam logic [RND_W-1:0] LAST_RND  = RND_W'(ROUNDS - 1);
  localparam logic [RND_W-1:0] LAST_LOAD = RND_W'(BLK_WORDS - 1);

  sched_state_e      state, state_nxt;
  logic [WORD_W-1:0] win [BLK_WORDS];
  logic [RND_W-1:0]  rnd_cnt;
  logic [WORD_W-1:0] s0, s1, gen_word, load_word;
  logic              out_free, start_ok, word_load;

  msg_sched_sigma #(.WORD_W(WORD_W)) u_sigma (
    .x0(win[1]),
    .x1(win[14]),
    .s0(s0),
    .s1(s1)
  );

  assign gen_word = s1 + win[9] + s0 + win[0];
  assign busy     = (state != IDLE);

  // Once the final word sits in the output register, GEN only waits for it to drain.
  always_comb begin
    state_nxt = state;
    out_free  = !w_valid || w_ready;
    m_ready   = 1'b0;
    word_load = 1'b0;
    load_word = gen_word;
    start_ok  = 1'b0;
    case (state)
      IDLE: begin
        if (blk_start) begin
          start_ok  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        m_ready   = out_free;
        load_word = m_data;
        word_load = m_valid && out_free;
        if (word_load && rnd_cnt == LAST_LOAD) state_nxt = GEN;
      end
      GEN: begin
        word_load = out_free && !w_last;
        if (w_valid && w_ready && w_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) begin
      state_nxt = IDLE;
      start_ok  = 1'b0;
      word_load = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The round counter parks at ROUNDS-1 so it never wraps inside a block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_valid <= 1'b0;
      w_data  <= '0;
      w_round <= '0;
      w_last  <= 1'b0;
      rnd_cnt <= '0;
      for (int i = 0; i < BLK_WORDS; i++) win[i] <= '0;
    end else if (abort) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end else if (start_ok) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
      rnd_cnt <= '0;
    end else if (word_load) begin
      w_valid <= 1'b1;
      w_data  <= load_word;
      w_round <= rnd_cnt;
      w_last  <= (rnd_cnt == LAST_RND);
      for (int i = 0; i < BLK_WORDS - 1; i++) win[i] <= win[i+1];
      win[BLK_WORDS-1] <= load_word;
      if (rnd_cnt != LAST_RND) rnd_cnt <= rnd_cnt + 1'b1;
    end else if (w_ready) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end
  end

`ifdef MSG_SCHED_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else if (start_ok) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (w_valid && !w_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      if (state == LOAD && m_ready && !m_valid && starve_cnt != 16'hFFFF)
        starve_cnt <= starve_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_msg_sched_stream.sv
// Self-checking bench: SHA-256 instance against a cycle model, SHA-512 instance against a schedule model.
module tb_msg_sched_stream;

  localparam int WA = 32;
  localparam int RA = 64;
  localparam int WB = 64;
  localparam int RB = 80;

  logic clk = 1'b0;
  logic reset;

  logic        blk_start, abort, m_valid, m_ready, w_valid, w_ready, w_last, busy;
  logic [31:0] m_data, w_data;
  logic [5:0]  w_round;

  logic        b_blk_start, b_abort, b_m_valid, b_m_ready, b_w_valid, b_w_ready, b_w_last, b_busy;
  logic [63:0] b_m_data, b_w_data;
  logic [6:0]  b_w_round;

`ifdef MSG_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt, starve_cnt, b_stall_cnt, b_starve_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [63:0] abcA [80];
  logic [63:0] abcB [80];
  logic [63:0] msgA [16];
  logic [63:0] model_w [80];
  logic [63:0] gotA [80];
  logic [63:0] gotB [80];

  always #5 clk = ~clk;

  msg_sched_stream #(.WORD_W(WA), .ROUNDS(RA)) dut_a (
    .clk(clk), .reset(reset), .blk_start(blk_start), .abort(abort),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_round(w_round), .w_last(w_last), .busy(busy)
`ifdef MSG_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`endif
  );

  msg_sched_stream #(.WORD_W(WB), .ROUNDS(RB)) dut_b (
    .clk(clk), .reset(reset), .blk_start(b_blk_start), .abort(b_abort),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
    .w_valid(b_w_valid), .w_ready(b_w_ready), .w_data(b_w_data),
    .w_round(b_w_round), .w_last(b_w_last), .busy(b_busy)
`ifdef MSG_SCHED_STALL_CNT_EN
    , .stall_cnt(b_stall_cnt), .starve_cnt(b_starve_cnt)
`endif
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] wmask(input int w);
    return (w == 32) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] m_rotr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & wmask(w);
  endfunction

  function automatic logic [63:0] m_sig0(input logic [63:0] x, input int w);
    if (w == 32) return m_rotr(x, 7, w) ^ m_rotr(x, 18, w) ^ (x >> 3);
    return m_rotr(x, 1, w) ^ m_rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] m_sig1(input logic [63:0] x, input int w);
    if (w == 32) return m_rotr(x, 17, w) ^ m_rotr(x, 19, w) ^ (x >> 10);
    return m_rotr(x, 19, w) ^ m_rotr(x, 61, w) ^ (x >> 6);
  endfunction

  function automatic logic [63:0] sched_word(input int w, input logic [63:0] wm16,
                                              input logic [63:0] wm15, input logic [63:0] wm7,
                                              input logic [63:0] wm2);
    return (m_sig1(wm2, w) + wm7 + m_sig0(wm15, w) + wm16) & wmask(w);
  endfunction

  // Reference model state for the SHA-256 instance, advanced once per cycle.
  bit          blk_active, exp_wv, exp_mr, mload, gload, waccept, prev_stall;
  int          mcnt, produced, taken, cyc, first_m_cyc, last_w_cyc, bn;
  int          model_stall, model_starve;
  logic [31:0] prev_data;
  logic [5:0]  prev_round;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      blk_active   = 0;
      mcnt         = 0;
      produced     = 0;
      taken        = 0;
      prev_stall   = 0;
      model_stall  = 0;
      model_starve = 0;
    end else begin
      exp_wv = blk_active && (produced > taken);
      exp_mr = blk_active && (mcnt < 16) && (!exp_wv || w_ready);
      checkOutput("busy", 64'(busy), 64'(blk_active));
      checkOutput("w_valid", 64'(w_valid), 64'(exp_wv));
      checkOutput("m_ready", 64'(m_ready), 64'(exp_mr));
      if (exp_wv) begin
        checkOutput("w_data", 64'(w_data), model_w[taken]);
        checkOutput("w_round", 64'(w_round), 64'(taken));
        checkOutput("w_last", 64'(w_last), 64'(taken == RA - 1));
      end
      if (prev_stall) begin
        checkOutput("hold_data", 64'(w_data), 64'(prev_data));
        checkOutput("hold_round", 64'(w_round), 64'(prev_round));
      end
`ifdef MSG_SCHED_STALL_CNT_EN
      checkOutput("stall_cnt", 64'(stall_cnt), 64'(model_stall));
      checkOutput("starve_cnt", 64'(starve_cnt), 64'(model_starve));
`endif
      if (exp_wv && !w_ready) model_stall++;
      if (exp_mr && !m_valid) model_starve++;
      prev_stall = exp_wv && !w_ready && !abort;
      prev_data  = w_data;
      prev_round = w_round;

      if (abort) begin
        blk_active = 0;
      end else if (!blk_active) begin
        if (blk_start) begin
          blk_active   = 1;
          mcnt         = 0;
          produced     = 0;
          taken        = 0;
          model_stall  = 0;
          model_starve = 0;
        end
      end else begin
        mload   = exp_mr && m_valid;
        gload   = (mcnt == 16) && (produced < RA) && (!exp_wv || w_ready);
        waccept = exp_wv && w_ready;
        if (waccept) begin
          gotA[taken] = 64'(w_data);
          if (taken == RA - 1) last_w_cyc = cyc;
          taken++;
          if (taken == RA) blk_active = 0;
        end
        if (mload) begin
          if (mcnt == 0) first_m_cyc = cyc;
          model_w[mcnt] = 64'(m_data);
          mcnt++;
          produced++;
          if (mcnt == 16)
            for (int t = 16; t < RA; t++)
              model_w[t] = sched_word(WA, model_w[t-16], model_w[t-15], model_w[t-7], model_w[t-2]);
        end
        if (gload) produced++;
      end

      if (b_w_valid && b_w_ready && bn < RB) begin
        checkOutput("b_w_round", 64'(b_w_round), 64'(bn));
        checkOutput("b_w_last", 64'(b_w_last), 64'(bn == RB - 1));
        gotB[bn] = b_w_data;
        bn++;
      end
      if (b_blk_start && !b_busy) bn = 0;
    end
  end

  task automatic applyStimulus(input bit rnd, input int abort_at, input int reset_at,
                               input bit extra_starts, input int stall_at);
    int mi, wn, stall_left, cyc_n;
    bit done, s5, s40, stalled, did_abort;
    mi = 0; wn = 0; stall_left = 0; cyc_n = 0;
    done = 0; s5 = 0; s40 = 0; stalled = 0; did_abort = 0;
    @(posedge clk); #1;
    blk_start = 1; abort = 0; m_valid = 0; w_ready = 1;
    @(posedge clk); #1;
    blk_start = 0;
    while (!done && cyc_n < 3000) begin
      cyc_n++;
      m_valid = rnd ? 1'($urandom_range(0, 1)) : (mi < 16);
      m_data  = (mi < 16) ? msgA[mi][31:0] : $urandom;
      w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_at >= 0 && wn == stall_at && !stalled) begin
        stall_left = 10;
        stalled    = 1;
      end
      if (stall_left > 0) begin
        w_ready = 0;
        stall_left--;
      end
      abort     = (abort_at >= 0 && wn == abort_at);
      blk_start = extra_starts && ((mi == 5 && !s5) || (wn == 40 && !s40));
      if (mi == 5) s5 = 1;
      if (wn == 40) s40 = 1;
      if (reset_at >= 0 && wn == reset_at) begin
        reset = 1; blk_start = 0; abort = 0;
        #1;
        checkOutput("rst_w_valid", 64'(w_valid), 64'd0);
        checkOutput("rst_w_data", 64'(w_data), 64'd0);
        checkOutput("rst_w_round", 64'(w_round), 64'd0);
        checkOutput("rst_w_last", 64'(w_last), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        blk_start = 1;
        @(posedge clk); #1;
        blk_start = 0;
        reset = 0;
        @(negedge clk);
        checkOutput("rst_start_ignored", 64'(busy), 64'd0);
        @(posedge clk); #1;
        done = 1;
      end else begin
        @(negedge clk);
        if (m_valid && m_ready) mi++;
        if (w_valid && w_ready) begin
          wn++;
          if (w_last) done = 1;
        end
        if (abort) begin
          done = 1;
          did_abort = 1;
        end
        @(posedge clk); #1;
      end
    end
    blk_start = 0; abort = 0; m_valid = 0; w_ready = 1;
    checkOutput("block_done", 64'(done), 64'd1);
    if (did_abort) begin
      checkOutput("abort_w_valid", 64'(w_valid), 64'd0);
      checkOutput("abort_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int bmi, budget;
    reset = 1;
    blk_start = 0; abort = 0; m_valid = 0; m_data = '0; w_ready = 1;
    b_blk_start = 0; b_abort = 0; b_m_valid = 0; b_m_data = '0; b_w_ready = 1;

    for (int i = 0; i < 80; i++) begin
      abcA[i] = '0;
      abcB[i] = '0;
    end
    abcA[0]  = 64'h6162_6380;
    abcA[15] = 64'h18;
    abcB[0]  = 64'h6162_6380_0000_0000;
    abcB[15] = 64'h18;
    for (int t = 16; t < RA; t++)
      abcA[t] = sched_word(WA, abcA[t-16], abcA[t-15], abcA[t-7], abcA[t-2]);
    for (int t = 16; t < RB; t++)
      abcB[t] = sched_word(WB, abcB[t-16], abcB[t-15], abcB[t-7], abcB[t-2]);
    checkOutput("model_256_w16", abcA[16], 64'h6162_6380);
    checkOutput("model_256_w17", abcA[17], 64'h000F_0000);
    checkOutput("model_256_w18", abcA[18], 64'h7DA8_6405);
    checkOutput("model_512_w16", abcB[16], 64'h6162_6380_0000_0000);
    checkOutput("model_512_w17", abcB[17], 64'h0003_0000_0000_00C0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_w_valid", 64'(w_valid), 64'd0);
    checkOutput("reset_w_data", 64'(w_data), 64'd0);
    checkOutput("reset_w_round", 64'(w_round), 64'd0);
    checkOutput("reset_m_ready", 64'(m_ready), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    reset = 0;

    for (int i = 0; i < 16; i++) msgA[i] = abcA[i];

    applyStimulus(0, -1, -1, 0, -1);
    checkOutput("abc_span", 64'(last_w_cyc - first_m_cyc), 64'd64);
    checkOutput("abc_w16", gotA[16], 64'h6162_6380);
    checkOutput("abc_w17", gotA[17], 64'h000F_0000);
    checkOutput("abc_w18", gotA[18], 64'h7DA8_6405);

    applyStimulus(1, -1, -1, 0, -1);
    for (int i = 0; i < RA; i++) checkOutput("rand_vs_abc", gotA[i], abcA[i]);

    for (int i = 0; i < 16; i++) msgA[i] = 64'($urandom);
    applyStimulus(1, -1, -1, 0, -1);
    for (int i = 0; i < 16; i++) msgA[i] = abcA[i];

    applyStimulus(0, 30, -1, 0, -1);
    applyStimulus(0, -1, -1, 0, -1);
    for (int i = 0; i < RA; i++) checkOutput("post_abort_vs_abc", gotA[i], abcA[i]);

    applyStimulus(0, -1, 20, 0, -1);
    applyStimulus(1, -1, -1, 0, -1);
    checkOutput("post_reset_w63", gotA[63], abcA[63]);

    applyStimulus(0, -1, -1, 1, -1);
    for (int i = 0; i < RA; i++) checkOutput("extra_start_vs_abc", gotA[i], abcA[i]);

    applyStimulus(0, -1, -1, 0, 17);
`ifdef MSG_SCHED_STALL_CNT_EN
    checkOutput("stall_cnt_10", 64'(stall_cnt), 64'd10);
    checkOutput("starve_cnt_0", 64'(starve_cnt), 64'd0);
`endif

    @(posedge clk); #1;
    b_blk_start = 1;
    @(posedge clk); #1;
    b_blk_start = 0;
    bmi = 0;
    budget = 0;
    while (bn < RB && budget < 1000) begin
      budget++;
      b_m_valid = (bmi < 16);
      b_m_data  = (bmi < 16) ? abcB[bmi] : '0;
      @(negedge clk);
      if (b_m_valid && b_m_ready) bmi++;
      @(posedge clk); #1;
    end
    b_m_valid = 0;
    checkOutput("b_word_count", 64'(bn), 64'(RB));
    checkOutput("b_w16", gotB[16], 64'h6162_6380_0000_0000);
    checkOutput("b_w17", gotB[17], 64'h0003_0000_0000_00C0);
    for (int i = 0; i < RB; i++) checkOutput("b_sched", gotB[i], abcB[i]);
    @(negedge clk);
    checkOutput("b_idle", 64'(b_busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
